// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen: butterfly address / twiddle sequencer for an in-place radix-2 DIT NTT of N = 2^LOG_N.
// Latency: valid rises one cycle after start is sampled in IDLE; done pulses one cycle after the final transfer.
// Backpressure: ready=0 holds every output and counter; all outputs come from registered state only.
// Optional macro NTT_STAGE_GAP_EN inserts STAGE_GAP bubble cycles (GAP state) between stages.
module ntt_addr_gen #(
    parameter int LOG_N     = 4,
    parameter int STG_W     = 2,
    parameter int STAGE_GAP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ready,
    output logic             valid,
    output logic [LOG_N-1:0] addr_a,
    output logic [LOG_N-1:0] addr_b,
    output logic [LOG_N-2:0] tw_idx,
    output logic [STG_W-1:0] stage,
    output logic             busy,
    output logic             done
);

    localparam logic [STG_W-1:0] S_LAST = STG_W'(LOG_N - 1);
    localparam logic [LOG_N-2:0] J_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [STG_W-1:0] r_s;
    logic [STG_W-1:0] w_s_nxt;
    logic [LOG_N-2:0] r_j;
    logic [LOG_N-2:0] w_j_nxt;

`ifdef NTT_STAGE_GAP_EN
    localparam logic [3:0] GAP_LOAD = 4'(STAGE_GAP - 1);
    logic [3:0] r_gap;
    logic [3:0] w_gap_nxt;
`endif

    // Address arithmetic: half = 2^s, pos = j mod half, grp = j >> s.
    // Bit s of addr_a is always zero, so addr_a + half reduces to an OR.
    logic [LOG_N-1:0] w_half;
    logic [LOG_N-2:0] w_pos;
    logic [LOG_N-2:0] w_grp;
    logic [STG_W:0]   w_sh_a;
    logic [STG_W:0]   w_sh_tw;
    logic [LOG_N-1:0] w_addr_a;
    logic [LOG_N-1:0] w_addr_b;
    logic [LOG_N-2:0] w_tw;

    assign w_half   = LOG_N'(1) << r_s;
    assign w_pos    = r_j & (w_half[LOG_N-2:0] - (LOG_N-1)'(1));
    assign w_grp    = r_j >> r_s;
    assign w_sh_a   = {1'b0, r_s} + (STG_W+1)'(1);
    assign w_sh_tw  = (STG_W+1)'(LOG_N - 1) - {1'b0, r_s};
    assign w_addr_a = ({1'b0, w_grp} << w_sh_a) | {1'b0, w_pos};
    assign w_addr_b = w_addr_a | w_half;
    assign w_tw     = w_pos << w_sh_tw;

    // State, stage and butterfly registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_j     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_j     <= w_j_nxt;
        end
    end

`ifdef NTT_STAGE_GAP_EN
    // Bubble counter for the inter-stage gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gap <= '0;
        end else begin
            r_gap <= w_gap_nxt;
        end
    end
`endif

    // Next-state logic and registered-state-only outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_j_nxt     = r_j;
`ifdef NTT_STAGE_GAP_EN
        w_gap_nxt   = r_gap;
`endif
        valid  = 1'b0;
        done   = 1'b0;
        busy   = (r_state != ST_IDLE);
        addr_a = '0;
        addr_b = '0;
        tw_idx = '0;
        stage  = r_s;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                valid  = 1'b1;
                addr_a = w_addr_a;
                addr_b = w_addr_b;
                tw_idx = w_tw;
                if (ready) begin
                    if (r_j != J_LAST) begin
                        w_j_nxt = r_j + 1'b1;
                    end else if (r_s != S_LAST) begin
                        w_j_nxt = '0;
`ifdef NTT_STAGE_GAP_EN
                        w_state_nxt = ST_GAP;
                        w_gap_nxt   = GAP_LOAD;
`else
                        w_s_nxt = r_s + 1'b1;
`endif
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_s_nxt     = '0;
                w_j_nxt     = '0;
                w_state_nxt = ST_IDLE;
            end
`ifdef NTT_STAGE_GAP_EN
            ST_GAP: begin
                if (r_gap == 4'd0) begin
                    w_state_nxt = ST_RUN;
                    w_s_nxt     = r_s + 1'b1;
                    w_j_nxt     = '0;
                end else begin
                    w_gap_nxt = r_gap - 4'd1;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/ntt_addr_gen.md
Name: ntt_addr_gen

Overview:
- Sequences butterfly operand addresses and twiddle indices for an iterative radix-2 in-place NTT of N = 2^LOG_N points (DIT, bit-reversed input order).
- Sits directly downstream of the generic counter primitive and upstream of the butterfly unit and coefficient RAM read ports.
- Walks every (stage, butterfly) pair once per start, emitting one address tuple per accepted valid/ready transfer.
- Signals completion with a one-cycle done pulse.

Parameters:
- LOG_N, 4, log2 of transform length; legal range 2..12; N = 2^LOG_N.
- STG_W, 2, stage field width; must equal ceil(log2(LOG_N)) and be at least 1.
- STAGE_GAP, 2, bubble cycles between stages; used only when NTT_STAGE_GAP_EN is defined; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  begin a transform; sampled only in IDLE.
- ready  in  1  downstream accepts the current tuple.
- valid  out  1  addr_a/addr_b/tw_idx/stage are meaningful.
- addr_a  out  LOG_N  upper-input coefficient address.
- addr_b  out  LOG_N  lower-input coefficient address.
- tw_idx  out  LOG_N-1  twiddle exponent k for w_N^k.
- stage  out  STG_W  current stage s.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-high (rst).
  - Asserting rst forces IDLE and clears s and j to 0.
  - While in reset, valid=0, busy=0, done=0, addr_a=0, addr_b=0, tw_idx=0, stage=0.
  - rst mid-run aborts immediately with no done pulse; the next start restarts from s=0, j=0.
- State registers:
  - stage counter s, 0..LOG_N-1.
  - butterfly counter j, LOG_N-1 bits, 0..N/2-1.
  - FSM state.
  - All updates on the rising edge of clk.
- Outputs:
  - Combinational functions of registered state only; no combinational path from start or ready to any output.
- Address arithmetic, with half = 2^s, pos = j mod half, grp = j >> s:
  - addr_a = (grp << (s+1)) | pos.
  - addr_b = addr_a + half. No overflow: addr_b is at most N-1.
  - tw_idx = pos << (LOG_N-1-s), truncated to LOG_N-1 bits.
- FSM transitions:
  - IDLE: valid=0. start=1 -> RUN with s=0, j=0; valid rises on the next cycle (latency 1 from start sampled).
  - RUN: valid=1.
    - valid&&ready with j<N/2-1: j++.
    - valid&&ready with j=N/2-1 and s<LOG_N-1: j=0, s++.
    - valid&&ready with j=N/2-1 and s=LOG_N-1: go to DONE.
    - ready=0: all outputs and counters hold.
  - DONE: valid=0, busy=1, done=1 for exactly one cycle; s and j cleared; next state IDLE.
- Transfer count and timing:
  - Total transfers per transform = (N/2)*LOG_N, which is 32 for LOG_N=4.
  - With ready held high, done rises exactly (N/2)*LOG_N+1 cycles after the cycle start was sampled.
- start asserted while not in IDLE is ignored and is not queued. start held high across DONE starts a new run from IDLE on the following cycle.

Optional Feature:
- Macro NTT_STAGE_GAP_EN.
- Defined:
  - Adds state GAP.
  - The final transfer of each non-final stage moves to GAP instead of RUN.
  - GAP holds valid=0 and busy=1 for STAGE_GAP cycles, then returns to RUN with s incremented and j=0.
  - Purpose: lets the butterfly pipeline write back before the next stage reads.
  - The final stage goes directly to DONE with no gap.
  - Total run length increases by (LOG_N-1)*STAGE_GAP cycles.
- Undefined: GAP state and its counter are absent; the STAGE_GAP parameter is ignored.

Test Plan:
1. Reset: assert rst mid-cycle, async, with no clock edge -> all outputs 0 immediately; start ignored while rst=1.
2. LOG_N=4, ready=1, single start pulse, expected tuple sequence (a,b,tw):
   - s0: (0,1,0), (2,3,0), ...
   - s1: j0=(0,2,0), j1=(1,3,4).
   - s3 j7: (7,15,7).
   - Exactly 32 valid cycles; done pulse on the cycle after the last transfer.
3. Backpressure: drop ready for 3 cycles at s=2, j=5 -> outputs (9,13,2) held stable; the sequence resumes with no skipped or duplicated tuple.
4. start re-asserted at s=1 -> ignored; exactly 32 transfers and one done pulse.
5. rst pulse at s=2, j=3 -> valid=0 and busy=0 immediately; a new start emits (0,1,0) first; no done pulse from the aborted run.
6. NTT_STAGE_GAP_EN defined with STAGE_GAP=2 -> 2 valid=0, busy=1 cycles after each of stages 0..2; done occurs 6 cycles later than in scenario 2.
